// File: rtl/fpaddsub_pkg.sv
// Shared widths, exception bit indices and stage bundles
// for the fp add/sub input-check front end.
package fpaddsub_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int WORD_W = 1 + EXP_W + FRAC_W;

    localparam int EXC_NAN_ANY = 0;
    localparam int EXC_NAN_A   = 1;
    localparam int EXC_NAN_B   = 2;
    localparam int EXC_INF     = 3;
    localparam int EXC_INV     = 4;

    localparam logic [WORD_W-1:0] QNAN = 32'h7FC00000;

    typedef struct packed {
        logic [WORD_W-1:0] a;
        logic [WORD_W-1:0] b;
        logic              nan_a;
        logic              nan_b;
        logic              inf_a;
        logic              inf_b;
    } s1_t;

    typedef struct packed {
        logic [WORD_W-1:0] a_big;
        logic [WORD_W-1:0] b_small;
        logic              swapped;
        logic              eff_sub;
        logic [4:0]        input_exc;
        logic [WORD_W-1:0] special_result;
    } s2_t;

endpackage

// File: rtl/fpaddsub_classify.sv
// Per-operand special-value classification and
// denormal flush to signed zero.
module fpaddsub_classify
    import fpaddsub_pkg::*;
(
    input  logic [WORD_W-1:0] x,
    output logic [WORD_W-1:0] flushed,
    output logic              is_nan,
    output logic              is_inf,
    output logic              is_zero
);

    logic [EXP_W-1:0]  e;
    logic [FRAC_W-1:0] f;
    logic              e_max;

    assign e       = x[WORD_W-2:FRAC_W];
    assign f       = x[FRAC_W-1:0];
    assign e_max   = &e;
    assign is_nan  = e_max & (|f);
    assign is_inf  = e_max & ~(|f);
    assign is_zero = ~(|e);

    always_comb begin
        flushed = x;
        if (is_zero) begin
            flushed = {x[WORD_W-1], {(WORD_W-1){1'b0}}};
        end
    end

endmodule

// File: rtl/fpaddsub_input_check.sv
// Two-stage front end: classify, then order by magnitude
// and form the exception vector and bypass value.
module fpaddsub_input_check
    import fpaddsub_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        op,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] a_big,
    output logic [31:0] b_small,
    output logic        swapped,
    output logic        eff_sub,
    output logic [4:0]  input_exc,
    output logic        special,
    output logic [31:0] special_result
);

    logic s1_valid;
    logic s2_valid;
    s1_t  s1_q;
    s1_t  s1_d;
    s2_t  s2_q;
    s2_t  s2_d;

    logic [WORD_W-1:0] b_eff;
    logic              zero_a;
    logic              zero_b;

    logic s2_load;
    logic s1_load;

    assign b_eff = {b[WORD_W-1] ^ op, b[WORD_W-2:0]};

    fpaddsub_classify u_cls_a (
        .x       (a),
        .flushed (s1_d.a),
        .is_nan  (s1_d.nan_a),
        .is_inf  (s1_d.inf_a),
        .is_zero (zero_a)
    );

    fpaddsub_classify u_cls_b (
        .x       (b_eff),
        .flushed (s1_d.b),
        .is_nan  (s1_d.nan_b),
        .is_inf  (s1_d.inf_b),
        .is_zero (zero_b)
    );

    // Each stage refills when empty or when its content moves on.
    assign s2_load  = ~s2_valid | out_ready;
    assign in_ready = ~s1_valid | s2_load;
    assign s1_load  = in_valid & in_ready;

    always_comb begin
        logic swap;
        logic sub;
        logic nan_any;
        logic [4:0] exc;
        swap    = s1_q.b[WORD_W-2:0] > s1_q.a[WORD_W-2:0];
        sub     = s1_q.a[WORD_W-1] ^ s1_q.b[WORD_W-1];
        nan_any = s1_q.nan_a | s1_q.nan_b;
        exc                 = '0;
        exc[EXC_NAN_ANY]    = nan_any;
        exc[EXC_NAN_A]      = s1_q.nan_a;
        exc[EXC_NAN_B]      = s1_q.nan_b;
        exc[EXC_INF]        = ~nan_any &
                              ((s1_q.inf_a ^ s1_q.inf_b) |
                               (s1_q.inf_a & s1_q.inf_b & ~sub));
        exc[EXC_INV]        = s1_q.inf_a & s1_q.inf_b & sub;

        s2_d.a_big          = swap ? s1_q.b : s1_q.a;
        s2_d.b_small        = swap ? s1_q.a : s1_q.b;
        s2_d.swapped        = swap;
        s2_d.eff_sub        = sub;
        s2_d.input_exc      = exc;
        s2_d.special_result = '0;
        if (exc[EXC_NAN_ANY] | exc[EXC_INV]) begin
            s2_d.special_result = QNAN;
        end else if (exc[EXC_INF]) begin
            s2_d.special_result = s1_q.inf_a ? s1_q.a : s1_q.b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_q     <= '0;
            s2_q     <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (s1_load) begin
                s1_q <= s1_d;
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
            end
            if (s2_load & s1_valid) begin
                s2_q <= s2_d;
            end
        end
    end

    assign out_valid      = s2_valid;
    assign a_big          = s2_q.a_big;
    assign b_small        = s2_q.b_small;
    assign swapped        = s2_q.swapped;
    assign eff_sub        = s2_q.eff_sub;
    assign input_exc      = s2_q.input_exc;
    assign special        = |s2_q.input_exc;
    assign special_result = s2_q.special_result;

endmodule

// File: tb/tb_fpaddsub_input_check.sv
// Scoreboard bench: stimulus pushes expected results,
// a monitor compares whatever the DUT presents.
module tb_fpaddsub_input_check;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] a_big;
        logic [31:0] b_small;
        logic        swapped;
        logic        eff_sub;
        logic [4:0]  exc;
        logic [31:0] sres;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, b;
    logic        op;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] a_big, b_small;
    logic        swapped, eff_sub;
    logic [4:0]  input_exc;
    logic        special;
    logic [31:0] special_result;

    int total = 0;
    int bad = 0;
    int accept_cnt = 0;
    int pop_cnt = 0;
    int cur = 0;

    vec_t tbl [10];
    vec_t exp_q [$];

    always #5 clk = ~clk;

    fpaddsub_input_check dut (
        .clk            (clk),
        .rst            (rst),
        .a              (a),
        .b              (b),
        .op             (op),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .a_big          (a_big),
        .b_small        (b_small),
        .swapped        (swapped),
        .eff_sub        (eff_sub),
        .input_exc      (input_exc),
        .special        (special),
        .special_result (special_result)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Pre-edge sampling: DUT state updates land in NBA.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                pop_cnt++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(tbl[cur]);
                accept_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        vec_t e;
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'd1, 32'd0);
            end else begin
                e = exp_q[0];
                check("a_big", a_big, e.a_big);
                check("b_small", b_small, e.b_small);
                check("swapped", {31'd0, swapped}, {31'd0, e.swapped});
                check("eff_sub", {31'd0, eff_sub}, {31'd0, e.eff_sub});
                check("input_exc", {27'd0, input_exc}, {27'd0, e.exc});
                check("special", {31'd0, special},
                      {31'd0, (e.exc != 5'd0)});
                check("special_result", special_result, e.sres);
            end
        end
    end

    task automatic send(input int idx);
        int n;
        bit ok;
        @(negedge clk);
        cur = idx;
        a = tbl[idx].a;
        b = tbl[idx].b;
        op = tbl[idx].op;
        in_valid = 1'b1;
        n = accept_cnt;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            if (accept_cnt != n) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && exp_q.size() > 0; k++) @(negedge clk);
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        tbl[0] = '{32'h3F800000, 32'h40000000, 1'b0,
                   32'h40000000, 32'h3F800000, 1'b1, 1'b0, 5'b00000, 32'h0};
        tbl[1] = '{32'h7F800000, 32'h7F800000, 1'b1,
                   32'h7F800000, 32'hFF800000, 1'b0, 1'b1, 5'b10000, 32'h7FC00000};
        tbl[2] = '{32'h7FC00001, 32'h3F800000, 1'b0,
                   32'h7FC00001, 32'h3F800000, 1'b0, 1'b0, 5'b00011, 32'h7FC00000};
        tbl[3] = '{32'hFF800000, 32'h40A00000, 1'b0,
                   32'hFF800000, 32'h40A00000, 1'b0, 1'b1, 5'b01000, 32'hFF800000};
        tbl[4] = '{32'h00000001, 32'h80000000, 1'b0,
                   32'h00000000, 32'h80000000, 1'b0, 1'b1, 5'b00000, 32'h0};
        tbl[5] = '{32'h3F800000, 32'h3F800000, 1'b1,
                   32'h3F800000, 32'hBF800000, 1'b0, 1'b1, 5'b00000, 32'h0};
        tbl[6] = '{32'h3F800000, 32'hFFC00000, 1'b0,
                   32'hFFC00000, 32'h3F800000, 1'b1, 1'b1, 5'b00101, 32'h7FC00000};
        tbl[7] = '{32'h7F800000, 32'h7F800000, 1'b0,
                   32'h7F800000, 32'h7F800000, 1'b0, 1'b0, 5'b01000, 32'h7F800000};
        tbl[8] = '{32'h40000000, 32'h00400000, 1'b1,
                   32'h40000000, 32'h80000000, 1'b0, 1'b1, 5'b00000, 32'h0};
        tbl[9] = '{32'h40000000, 32'hFF800000, 1'b1,
                   32'h7F800000, 32'h40000000, 1'b1, 1'b0, 5'b01000, 32'h7F800000};

        rst = 1'b1;
        a = '0;
        b = '0;
        op = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_a_big", a_big, 32'd0);
        check("rst_b_small", b_small, 32'd0);
        check("rst_exc", {27'd0, input_exc}, 32'd0);
        check("rst_sres", special_result, 32'd0);

        // latency: drive in one cycle, output two edges later
        send(0);
        in_valid = 1'b0;
        check("lat_not_early", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("lat_out_valid", {31'd0, out_valid}, 32'd1);
        idle(2);

        for (int i = 1; i < 10; i++) send(i);
        idle(1);
        drain();

        // backpressure: two accepted, then in_ready low
        @(negedge clk);
        out_ready = 1'b0;
        accept_cnt = 0;
        pop_cnt = 0;
        fork
            begin
                send(2);
                send(3);
                send(6);
                send(9);
                idle(0);
            end
            begin
                repeat (3) @(negedge clk);
                #1;
                check("bp_accepted", accept_cnt, 32'd2);
                check("bp_in_ready", {31'd0, in_ready}, 32'd0);
                check("bp_out_valid", {31'd0, out_valid}, 32'd1);
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_popped", pop_cnt, 32'd4);

        // reset with two pairs in flight
        @(negedge clk);
        out_ready = 1'b0;
        send(5);
        send(7);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_q", exp_q.size(), 32'd0);
        repeat (5) @(negedge clk);
        check("midrst_quiet", {31'd0, out_valid}, 32'd0);

        send(8);
        idle(1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

endmodule
